// File: rtl/spi_master_scheduler_pkg.sv
// Shared SPI definitions: frame width, clock polarity and scheduler state encoding.
package spi_master_scheduler_pkg;

    localparam int unsigned SPI_FRAME_W = 8;
    localparam int unsigned SPI_BIT_W   = $clog2(SPI_FRAME_W);
    // Mode 0: SCLK idles low, data captured on the rising edge
    localparam logic        SPI_CPOL    = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold
    } spi_state_e;

endpackage

// File: rtl/spi_master_scheduler_if.sv
// System-side request bus shared by all requesters of the SPI scheduler.
interface spi_master_scheduler_if
    import spi_master_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]             req_bi;
    logic [SPI_FRAME_W*NUM_REQ-1:0] wdata_bi;
    logic [NUM_REQ-1:0]             grant_bo;
    logic [NUM_REQ-1:0]             done_bo;
    logic [SPI_FRAME_W-1:0]         rdata_bo;
    logic                           busy_o;

    // Requester side
    modport master (
        output req_bi, wdata_bi,
        input  grant_bo, done_bo, rdata_bo, busy_o
    );

    // Scheduler side
    modport slave (
        input  req_bi, wdata_bi,
        output grant_bo, done_bo, rdata_bo, busy_o
    );
endinterface

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module spi_master_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Scan from the pointer and take the first requester found
    always_comb begin
        int unsigned j;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            j = (int'(ptr_i) + off) % NUM_REQ;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_master_scheduler.sv
// Mode-0 SPI master shared by NUM_REQ requesters; requester i always talks to slave i.
module spi_master_scheduler
    import spi_master_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    spi_master_scheduler_if.slave bus,
    output logic               spi_sclk_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i,
    output logic [NUM_REQ-1:0] spi_cs_bo
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    spi_state_e             state_q;
    logic [DivW-1:0]        div_q;
    logic [SPI_BIT_W-1:0]   bit_q;
    logic [IdxW-1:0]        idx_q;
    logic [IdxW-1:0]        rr_q;
    logic [SPI_FRAME_W-1:0] tx_q;
    logic [SPI_FRAME_W-1:0] rx_q;
    logic [SPI_FRAME_W-1:0] rdata_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [NUM_REQ-1:0]     done_q;
    logic [NUM_REQ-1:0]     cs_q;
    logic                   sclk_q;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IdxW-1:0]        arb_idx;
    logic                   arb_valid;
    logic                   div_last;
    logic [IdxW-1:0]        rr_next;

    spi_master_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_arb (
        .req_i   (bus.req_bi),
        .ptr_i   (rr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Divider terminal count and the round-robin successor of the current requester
    always_comb begin
        div_last = (div_q == DivW'(CLK_DIV - 1));
        rr_next  = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + IdxW'(1);
    end

    // Frame sequencer: arbitration, SCLK generation, shifting and completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            cs_q    <= '1;
            sclk_q  <= SPI_CPOL;
        end else begin
            done_q <= '0;
            case (state_q)
                StIdle: begin
                    div_q <= '0;
                    if (arb_valid) begin
                        idx_q   <= arb_idx;
                        tx_q    <= bus.wdata_bi[SPI_FRAME_W*int'(arb_idx) +: SPI_FRAME_W];
                        grant_q <= arb_gnt;
                        cs_q    <= ~arb_gnt;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (div_last) begin
                        div_q   <= '0;
                        sclk_q  <= ~SPI_CPOL;
                        state_q <= StHigh;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StHigh: begin
                    if (div_last) begin
                        div_q   <= '0;
                        rx_q    <= {rx_q[SPI_FRAME_W-2:0], spi_miso_i};
                        sclk_q  <= SPI_CPOL;
                        state_q <= StLow;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StLow: begin
                    // MOSI is tx_q[MSB], so the shift presents the next bit after SCLK falls
                    if (div_q == '0) begin
                        tx_q <= {tx_q[SPI_FRAME_W-2:0], 1'b0};
                    end
                    if (div_last) begin
                        div_q <= '0;
                        bit_q <= bit_q + SPI_BIT_W'(1);
                        if (bit_q == SPI_BIT_W'(SPI_FRAME_W - 1)) begin
                            cs_q    <= '1;
                            state_q <= StHold;
                        end else begin
                            sclk_q  <= ~SPI_CPOL;
                            state_q <= StHigh;
                        end
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                StHold: begin
                    if (div_last) begin
                        div_q   <= '0;
                        rdata_q <= rx_q;
                        done_q  <= grant_q;
                        grant_q <= '0;
                        rr_q    <= rr_next;
                        state_q <= StIdle;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from registers
    always_comb begin
        bus.grant_bo = grant_q;
        bus.done_bo  = done_q;
        bus.rdata_bo = rdata_q;
        bus.busy_o   = (state_q != StIdle);
        spi_sclk_o   = sclk_q;
        spi_mosi_o   = tx_q[SPI_FRAME_W-1];
        spi_cs_bo    = cs_q;
    end

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Directed scoreboard bench for spi_master_scheduler with behavioural mode-0 SPI slaves.
module tb_spi_master_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_scheduler_if #(.NUM_REQ(2)) bus4 ();
    spi_master_scheduler_if #(.NUM_REQ(2)) bus2 ();

    logic       sclk4, mosi4, miso4;
    logic [1:0] cs4;
    logic       sclk2, mosi2, miso2;
    logic [1:0] cs2;

    spi_master_scheduler #(
        .NUM_REQ (2),
        .CLK_DIV (4)
    ) u_dut4 (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus4),
        .spi_sclk_o (sclk4),
        .spi_mosi_o (mosi4),
        .spi_miso_i (miso4),
        .spi_cs_bo  (cs4)
    );

    spi_master_scheduler #(
        .NUM_REQ (2),
        .CLK_DIV (2)
    ) u_dut2 (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus2),
        .spi_sclk_o (sclk2),
        .spi_mosi_o (mosi2),
        .spi_miso_i (miso2),
        .spi_cs_bo  (cs2)
    );

    // Slaves 0/1 sit on the CLK_DIV=4 master, slave 2 on cs0 of the CLK_DIV=2 master
    logic [2:0] s_cs, s_sclk, s_mosi, s_miso;
    logic [7:0] slv_din  [3];
    logic [7:0] slv_dout [3];

    assign s_cs   = {cs2[0], cs4[1], cs4[0]};
    assign s_sclk = {sclk2, sclk4, sclk4};
    assign s_mosi = {mosi2, mosi4, mosi4};
    assign miso4  = (~cs4[0] & s_miso[0]) | (~cs4[1] & s_miso[1]);
    assign miso2  = ~cs2[0] & s_miso[2];

    for (genvar k = 0; k < 3; k++) begin : g_slv
        logic [7:0] sh, rx, dout;
        logic       so;
        initial begin
            sh = '0; rx = '0; dout = '0; so = 1'b0;
        end
        // Mode 0: MSB driven at CS fall, capture on SCLK rise, shift on SCLK fall
        always @(negedge s_cs[k]) begin
            sh = slv_din[k];
            so = sh[7];
        end
        always @(posedge s_sclk[k]) if (!s_cs[k]) rx = {rx[6:0], s_mosi[k]};
        always @(negedge s_sclk[k]) if (!s_cs[k]) begin
            sh = {sh[6:0], 1'b0};
            so = sh[7];
        end
        always @(posedge s_cs[k]) dout = rx;
        assign s_miso[k]   = so;
        assign slv_dout[k] = dout;
    end

    typedef struct packed {
        logic [1:0] gnt;
        logic [7:0] rdata;
        logic [7:0] tx;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         g_cyc = 0;
    int         hi_run = 0;
    int         cs1_low = 0;
    bit         seen = 1'b0;
    logic [1:0] prev_grant = 2'b00;
    logic [1:0] prev_cs = 2'b11;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock step plus the CLK_DIV=4 monitor: bus invariants and scoreboard pop on done
    task automatic tick();
        exp_t e;
        int   idx;
        @(negedge clk);
        cyc++;
        if (rst) begin
            hi_run     = 0;
            seen       = 1'b0;
            prev_cs    = 2'b11;
            prev_grant = 2'b00;
        end else begin
            if (prev_grant == 2'b00 && bus4.grant_bo != 2'b00) g_cyc = cyc;
            prev_grant = bus4.grant_bo;
            if (cs4 != 2'b11) begin
                check("cs_one_low", 32'($countones(~cs4)), 32'd1);
                if (prev_cs == 2'b11) begin
                    if (seen) check("cs_gap_ge5", 32'(hi_run >= 5), 32'd1);
                    seen = 1'b1;
                end
                hi_run = 0;
            end else begin
                hi_run++;
                check("sclk_idle", 32'(sclk4), 32'd0);
            end
            if (!cs4[1]) cs1_low++;
            prev_cs = cs4;
            if (bus4.done_bo != 2'b00) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(bus4.done_bo), 32'd0);
                end else begin
                    e   = sb.pop_front();
                    idx = int'(bus4.done_bo[1]);
                    check("done_idx", 32'(bus4.done_bo), 32'(e.gnt));
                    check("rdata", 32'(bus4.rdata_bo), 32'(e.rdata));
                    check("slave_rx", 32'(slv_dout[idx]), 32'(e.tx));
                    check("latency72", 32'(cyc - g_cyc), 32'd72);
                end
            end
        end
    endtask

    task automatic wait_done4(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = (bus4.done_bo != 2'b00);
        end
        check("done4_in_time", 32'(got), 32'd1);
    endtask

    initial begin
        int  rises;
        int  c1;
        int  g2;
        bit  got;
        logic prev_sclk;

        rst = 1'b1;
        bus4.req_bi = '0; bus4.wdata_bi = '0;
        bus2.req_bi = '0; bus2.wdata_bi = '0;
        for (int i = 0; i < 3; i++) slv_din[i] = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_grant", 32'(bus4.grant_bo), 32'd0);
        check("rst_done", 32'(bus4.done_bo), 32'd0);
        check("rst_rdata", 32'(bus4.rdata_bo), 32'd0);
        check("rst_busy", 32'(bus4.busy_o), 32'd0);
        check("rst_sclk", 32'(sclk4), 32'd0);
        check("rst_mosi", 32'(mosi4), 32'd0);
        check("rst_cs", 32'(cs4), 32'h3);
        check("rst_cs_d2", 32'(cs2), 32'h3);
        rst = 1'b0;
        tick();

        // Single frame on requester 0
        slv_din[0] = 8'h3C;
        bus4.wdata_bi = 16'h00A5;
        sb.push_back('{gnt: 2'b01, rdata: 8'h3C, tx: 8'hA5});
        c1 = cs1_low;
        bus4.req_bi = 2'b01;
        wait_done4(200);
        bus4.req_bi = 2'b00;
        check("cs1_never_low", 32'(cs1_low - c1), 32'd0);
        repeat (3) tick();
        check("rdata_held", 32'(bus4.rdata_bo), 32'h3C);
        check("idle_busy", 32'(bus4.busy_o), 32'd0);

        // Contention: pointer is 1 after the single frame, so 1,0,1,0
        slv_din[0] = 8'h11;
        slv_din[1] = 8'h22;
        bus4.wdata_bi = 16'hC35A;
        sb.push_back('{gnt: 2'b10, rdata: 8'h22, tx: 8'hC3});
        sb.push_back('{gnt: 2'b01, rdata: 8'h11, tx: 8'h5A});
        sb.push_back('{gnt: 2'b10, rdata: 8'h22, tx: 8'hC3});
        sb.push_back('{gnt: 2'b01, rdata: 8'h11, tx: 8'h5A});
        bus4.req_bi = 2'b11;
        repeat (4) wait_done4(200);
        bus4.req_bi = 2'b00;
        repeat (4) tick();
        check("cont_grant_idle", 32'(bus4.grant_bo), 32'd0);
        check("cont_sb_empty", 32'(sb.size()), 32'd0);

        // Pointer at 1 but only requester 0 asks: granted at once
        slv_din[0] = 8'hB4;
        bus4.wdata_bi = 16'h006E;
        sb.push_back('{gnt: 2'b01, rdata: 8'hB4, tx: 8'h6E});
        bus4.req_bi = 2'b01;
        tick();
        check("ptr_skip_grant", 32'(bus4.grant_bo), 32'h1);
        wait_done4(200);
        bus4.req_bi = 2'b00;
        tick();

        // Now both ask: pointer moved to 1
        slv_din[1] = 8'h4D;
        bus4.wdata_bi = 16'h9C00;
        sb.push_back('{gnt: 2'b10, rdata: 8'h4D, tx: 8'h9C});
        bus4.req_bi = 2'b11;
        tick();
        check("ptr_next_grant", 32'(bus4.grant_bo), 32'h2);
        wait_done4(200);
        bus4.req_bi = 2'b00;
        tick();

        // Reset after the third SCLK rise
        slv_din[0] = 8'h77;
        bus4.wdata_bi = 16'h0099;
        bus4.req_bi = 2'b01;
        rises = 0;
        prev_sclk = sclk4;
        for (int i = 0; i < 400 && rises < 3; i++) begin
            tick();
            if (sclk4 && !prev_sclk) rises++;
            prev_sclk = sclk4;
        end
        check("three_rises", 32'(rises), 32'd3);
        rst = 1'b1;
        bus4.req_bi = 2'b00;
        #1;
        check("mid_rst_cs", 32'(cs4), 32'h3);
        check("mid_rst_sclk", 32'(sclk4), 32'd0);
        check("mid_rst_busy", 32'(bus4.busy_o), 32'd0);
        check("mid_rst_rdata", 32'(bus4.rdata_bo), 32'd0);
        check("mid_rst_grant", 32'(bus4.grant_bo), 32'd0);
        check("mid_rst_done", 32'(bus4.done_bo), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Clean frame after the aborted one
        slv_din[0] = 8'h81;
        bus4.wdata_bi = 16'h00FF;
        sb.push_back('{gnt: 2'b01, rdata: 8'h81, tx: 8'hFF});
        bus4.req_bi = 2'b01;
        wait_done4(200);
        bus4.req_bi = 2'b00;
        tick();

        // Input churn mid-frame: the byte latched at grant is what goes out
        slv_din[0] = 8'hC5;
        bus4.wdata_bi = 16'h003A;
        sb.push_back('{gnt: 2'b01, rdata: 8'hC5, tx: 8'h3A});
        bus4.req_bi = 2'b01;
        repeat (20) tick();
        bus4.wdata_bi = 16'hFFFF;
        bus4.req_bi = 2'b00;
        wait_done4(200);
        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        // Minimum divider on the CLK_DIV=2 instance
        slv_din[2] = 8'h80;
        bus2.wdata_bi = 16'h0001;
        bus2.req_bi = 2'b01;
        tick();
        check("d2_grant", 32'(bus2.grant_bo), 32'h1);
        g2 = cyc;
        bus2.req_bi = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            got = (bus2.done_bo != 2'b00);
        end
        check("d2_done_in_time", 32'(got), 32'd1);
        check("d2_latency36", 32'(cyc - g2), 32'd36);
        check("d2_done_idx", 32'(bus2.done_bo), 32'h1);
        check("d2_rdata", 32'(bus2.rdata_bo), 32'h80);
        check("d2_slave_rx", 32'(slv_dout[2]), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
